// File: rtl/uart_host_sequencer_if.sv
// rtl/uart_host_sequencer_if.sv - host command/response handshake bundle for uart_host_sequencer
interface uart_host_sequencer_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [7:0] cmd_data;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_data;

  modport master (
    output cmd_valid, cmd_op, cmd_data, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_data
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_data, rsp_ready,
    output cmd_ready, rsp_valid, rsp_data
  );
endinterface

// File: rtl/uart_host_sequencer.sv
// rtl/uart_host_sequencer.sv - turns host byte commands into single-cycle UART control pulses
module uart_host_sequencer #(
  parameter logic [1:0] DEFAULT_RATE_SEL = 2'b00
) (
  input  logic                        clk,
  input  logic                        syncReset,
  uart_host_sequencer_if.slave        host,
  output logic [3:0]                  uart_control,
  output logic [7:0]                  uart_tx_data,
  input  logic [7:0]                  uart_rx_data,
  input  logic                        uart_rts,
  input  logic                        uart_err,
  output logic                        rx_full,
  output logic                        err
);

  localparam logic [1:0] OP_SET_RATE = 2'b00;
  localparam logic [1:0] OP_WRITE    = 2'b01;
  localparam logic [1:0] OP_READ     = 2'b10;

  typedef enum logic [1:0] {IDLE, PULSE, GAP, RESP} state_t;

  state_t     state;
  state_t     nextState;
  logic [1:0] opReg;
  logic [1:0] rateReg;
  logic [7:0] txData;
  logic [7:0] rspData;
  logic       rspValid;
  logic       rxFull;
  logic       errReg;
  logic       cmdReady;
  logic [1:0] pulseCode;
  logic       cmdFire;

  assign cmdFire = host.cmd_valid && cmdReady;

  always_ff @(posedge clk) begin
    if (syncReset) state <= IDLE;
    else           state <= nextState;
  end

  always_comb begin
    nextState = state;
    case (state)
      IDLE:    if (cmdFire && host.cmd_op != OP_SET_RATE) nextState = PULSE;
      PULSE:   nextState = GAP;
      GAP:     nextState = (opReg == OP_READ) ? RESP : IDLE;
      RESP:    if (host.rsp_ready) nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // The pulse code is decoded from state so it can never span two cycles.
  always_comb begin
    cmdReady  = (state == IDLE);
    pulseCode = 2'b00;
    if (state == PULSE) pulseCode = opReg;
  end

  always_ff @(posedge clk) begin
    if (syncReset) begin
      opReg    <= 2'b00;
      rateReg  <= DEFAULT_RATE_SEL;
      txData   <= 8'h00;
      rspData  <= 8'h00;
      rspValid <= 1'b0;
      rxFull   <= 1'b0;
      errReg   <= 1'b0;
    end else begin
      rxFull <= uart_rts;
      errReg <= uart_err;
      case (state)
        IDLE: begin
          if (cmdFire) begin
            if (host.cmd_op == OP_SET_RATE) begin
              rateReg <= host.cmd_data[1:0];
            end else begin
              opReg  <= host.cmd_op;
              txData <= (host.cmd_op == OP_WRITE) ? host.cmd_data : 8'h00;
            end
          end
        end
        // tx byte is held through GAP because the UART loads its FIFO then.
        GAP: begin
          txData <= 8'h00;
          if (opReg == OP_READ) begin
            rspData  <= uart_rx_data;
            rspValid <= 1'b1;
          end
        end
        RESP: begin
          if (host.rsp_ready) rspValid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign host.cmd_ready = cmdReady;
  assign host.rsp_valid = rspValid;
  assign host.rsp_data  = rspData;
  assign uart_control   = {pulseCode, rateReg};
  assign uart_tx_data   = txData;
  assign rx_full        = rxFull;
  assign err            = errReg;

endmodule

// File: tb/tb_uart_host_sequencer.sv
// tb/tb_uart_host_sequencer.sv - directed and randomized checks of uart_host_sequencer
module tb_uart_host_sequencer;
  logic       clk = 1'b0;
  logic       syncReset;
  logic [3:0] uart_control;
  logic [7:0] uart_tx_data;
  logic [7:0] uart_rx_data;
  logic       uart_rts;
  logic       uart_err;
  logic       rx_full;
  logic       err;

  int nCmp  = 0;
  int nFail = 0;

  uart_host_sequencer_if hif ();

  uart_host_sequencer #(.DEFAULT_RATE_SEL(2'b00)) dut (
    .clk          (clk),
    .syncReset    (syncReset),
    .host         (hif.slave),
    .uart_control (uart_control),
    .uart_tx_data (uart_tx_data),
    .uart_rx_data (uart_rx_data),
    .uart_rts     (uart_rts),
    .uart_err     (uart_err),
    .rx_full      (rx_full),
    .err          (err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nCmp++;
    assert (obs === exp) else begin
      nFail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] pulseFor(input logic [1:0] op);
    case (op)
      2'b01:   return 2'b01;
      2'b10:   return 2'b10;
      2'b11:   return 2'b11;
      default: return 2'b00;
    endcase
  endfunction

  initial begin
    logic [1:0] rate;
    logic [1:0] seq[$];
    logic [1:0] expSeq[5];
    logic [1:0] op;
    logic [7:0] data;
    logic [7:0] rxByte;
    int         waitCycles;

    syncReset = 1'b1;
    hif.cmd_valid = 1'b0; hif.cmd_op = 2'b00; hif.cmd_data = 8'h00; hif.rsp_ready = 1'b0;
    uart_rx_data = 8'h00; uart_rts = 1'b0; uart_err = 1'b0;
    rate = 2'b00;

    // Reset
    tick(); tick();
    chk("rst_control", uart_control, 4'b0000);
    chk("rst_cmd_ready", hif.cmd_ready, 1'b1);
    chk("rst_rsp_valid", hif.rsp_valid, 1'b0);
    chk("rst_tx_data", uart_tx_data, 8'h00);
    syncReset = 1'b0;
    tick();

    // WRITE 0xA5
    hif.cmd_valid = 1'b1; hif.cmd_op = 2'b01; hif.cmd_data = 8'hA5;
    tick();
    hif.cmd_valid = 1'b0;
    chk("wr_t1_pulse", uart_control[3:2], 2'b01);
    chk("wr_t1_tx", uart_tx_data, 8'hA5);
    tick();
    chk("wr_t2_pulse", uart_control[3:2], 2'b00);
    chk("wr_t2_tx", uart_tx_data, 8'hA5);
    tick();
    chk("wr_t3_ready", hif.cmd_ready, 1'b1);
    chk("wr_t3_tx", uart_tx_data, 8'h00);

    // READ with rx byte valid only in GAP, then backpressure
    hif.cmd_valid = 1'b1; hif.cmd_op = 2'b10; hif.cmd_data = 8'hFF;
    tick();
    hif.cmd_valid = 1'b0;
    chk("rd_t1_pulse", uart_control[3:2], 2'b10);
    tick();
    uart_rx_data = 8'h3C;
    tick();
    uart_rx_data = 8'h00;
    chk("rd_t3_valid", hif.rsp_valid, 1'b1);
    chk("rd_t3_data", hif.rsp_data, 8'h3C);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("rd_hold_data", hif.rsp_data, 8'h3C);
      chk("rd_hold_ready", hif.cmd_ready, 1'b0);
      chk("rd_hold_valid", hif.rsp_valid, 1'b1);
    end
    hif.rsp_ready = 1'b1;
    tick();
    hif.rsp_ready = 1'b0;
    chk("rd_done_valid", hif.rsp_valid, 1'b0);
    chk("rd_done_ready", hif.cmd_ready, 1'b1);

    // SET_RATE 3, WRITE 0x11, CLEAR back-to-back with cmd_valid held
    hif.cmd_valid = 1'b1; hif.cmd_op = 2'b00; hif.cmd_data = 8'h03;
    tick();
    rate = 2'b11;
    chk("sr_rate", uart_control[1:0], rate);
    chk("sr_no_pulse", uart_control[3:2], 2'b00);
    chk("sr_ready", hif.cmd_ready, 1'b1);
    hif.cmd_op = 2'b01; hif.cmd_data = 8'h11;
    tick();
    chk("b2b_wr_tx", uart_tx_data, 8'h11);
    seq.push_back(uart_control[3:2]);
    chk("b2b_rate0", uart_control[1:0], rate);
    // Changes while busy must be ignored; CLEAR is taken only at the next IDLE.
    hif.cmd_op = 2'b11; hif.cmd_data = 8'h77;
    for (int i = 1; i < 5; i++) begin
      tick();
      seq.push_back(uart_control[3:2]);
      chk("b2b_rate", uart_control[1:0], rate);
      if (i == 3) hif.cmd_valid = 1'b0;
    end
    expSeq = '{2'b01, 2'b00, 2'b00, 2'b11, 2'b00};
    for (int i = 0; i < 5; i++) begin
      chk("b2b_seq", seq[i], expSeq[i]);
      if (i > 0) chk("b2b_adjacent", ((seq[i] != 2'b00) && (seq[i-1] != 2'b00)), 1'b0);
    end
    tick();
    chk("b2b_rate_idle", uart_control[1:0], rate);

    // Reset during GAP of a READ
    hif.cmd_valid = 1'b1; hif.cmd_op = 2'b10;
    tick();
    hif.cmd_valid = 1'b0;
    tick();
    uart_rx_data = 8'h5A;
    syncReset = 1'b1;
    tick();
    syncReset = 1'b0;
    uart_rx_data = 8'h00;
    rate = 2'b00;
    chk("rstgap_control", uart_control, 4'b0000);
    chk("rstgap_rsp_valid", hif.rsp_valid, 1'b0);
    chk("rstgap_ready", hif.cmd_ready, 1'b1);
    uart_err = 1'b1; uart_rts = 1'b1;
    tick();
    chk("rstgap_rsp_valid2", hif.rsp_valid, 1'b0);
    chk("err_copy", err, 1'b1);
    chk("rx_full_copy", rx_full, 1'b1);
    uart_err = 1'b0; uart_rts = 1'b0;
    tick();
    chk("err_clear", err, 1'b0);
    chk("rx_full_clear", rx_full, 1'b0);

    // Randomized command stream against the reference model
    for (int n = 0; n < 40; n++) begin
      op   = 2'($urandom_range(0, 3));
      data = 8'($urandom);
      chk("rnd_ready", hif.cmd_ready, 1'b1);
      hif.cmd_valid = 1'b1; hif.cmd_op = op; hif.cmd_data = data;
      tick();
      hif.cmd_valid = 1'b0;
      hif.cmd_op = 2'($urandom); hif.cmd_data = 8'($urandom);
      if (op == 2'b00) begin
        rate = data[1:0];
        chk("rnd_sr_control", uart_control, {2'b00, rate});
        continue;
      end
      chk("rnd_pulse", uart_control, {pulseFor(op), rate});
      chk("rnd_pulse_tx", uart_tx_data, (op == 2'b01) ? data : 8'h00);
      rxByte = 8'($urandom);
      tick();
      uart_rx_data = rxByte;
      chk("rnd_gap", uart_control, {2'b00, rate});
      chk("rnd_gap_tx", uart_tx_data, (op == 2'b01) ? data : 8'h00);
      tick();
      uart_rx_data = 8'h00;
      chk("rnd_after_control", uart_control, {2'b00, rate});
      chk("rnd_after_tx", uart_tx_data, 8'h00);
      if (op == 2'b10) begin
        chk("rnd_rsp_valid", hif.rsp_valid, 1'b1);
        chk("rnd_rsp_data", hif.rsp_data, rxByte);
        waitCycles = $urandom_range(0, 3);
        for (int w = 0; w < waitCycles; w++) begin
          tick();
          chk("rnd_rsp_hold", hif.rsp_data, rxByte);
          chk("rnd_rsp_busy", hif.cmd_ready, 1'b0);
        end
        hif.rsp_ready = 1'b1;
        tick();
        hif.rsp_ready = 1'b0;
        chk("rnd_rsp_drop", hif.rsp_valid, 1'b0);
      end else begin
        chk("rnd_no_rsp", hif.rsp_valid, 1'b0);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nFail);
    $finish;
  end
endmodule

// File: doc/uart_host_sequencer.md
Name: uart_host_sequencer

Overview:
- Host-side command stage directly upstream of the tapeout UART.
- Converts valid/ready byte commands (set rate, write byte, read byte, clear buffers) into the UART's edge-detected control protocol.
- Protocol: control[3:2] is held non-zero for exactly one cycle, then returned to 2'b00. Control[1:0] holds the rate select.
- Returns read bytes on a response handshake and mirrors UART flow/error status to the host.

Parameters:
- DEFAULT_RATE_SEL, 2'b00, rate-select value loaded into control[1:0] on reset (00 = default divisor 5207).

Ports:
- clk  input  1  system clock
- syncReset  input  1  synchronous reset, active-high
- cmd_valid  input  1  host command valid
- cmd_ready  output  1  sequencer can accept a command
- cmd_op  input  2  00 SET_RATE, 01 WRITE, 10 READ, 11 CLEAR
- cmd_data  input  8  WRITE: byte to send; SET_RATE: bits [1:0] = rate select; otherwise ignored
- rsp_valid  output  1  read byte available
- rsp_ready  input  1  host accepts read byte
- rsp_data  output  8  byte returned by READ
- uart_control  output  4  to UART control: [3:2] ren/wen pulse code, [1:0] rate select
- uart_tx_data  output  8  to UART tx_data
- uart_rx_data  input  8  from UART rx_data (valid only in the cycle after a READ pulse)
- uart_rts  input  1  from UART rts (rx buffer full)
- uart_err  input  1  from UART err (sticky)
- rx_full  output  1  registered copy of uart_rts
- err  output  1  registered copy of uart_err

Behaviour:
- All state is synchronous to clk. syncReset is sampled on rising edges and overrides everything else.
- Reset values:
  - state = IDLE; cmd_ready = 1; rsp_valid = 0; rsp_data = 0.
  - uart_control = {2'b00, DEFAULT_RATE_SEL}; uart_tx_data = 0; rx_full = 0; err = 0.
- Rate register: the only source of uart_control[1:0]. It is held constant except on SET_RATE.
- States: IDLE, PULSE, GAP, RESP.
- IDLE:
  - cmd_ready = 1; uart_control[3:2] = 00.
  - Handshake is cmd_valid && cmd_ready at a rising edge.
  - SET_RATE: rate register <= cmd_data[1:0]; stay in IDLE. uart_control[1:0] changes on the next cycle. No pulse is issued.
  - WRITE / READ / CLEAR: latch the op; for WRITE also uart_tx_data <= cmd_data. Go to PULSE.
- PULSE (exactly 1 cycle):
  - cmd_ready = 0.
  - uart_control[3:2] = 01 (WRITE), 10 (READ) or 11 (CLEAR).
  - uart_tx_data stays at the latched byte. Next state is GAP.
- GAP (exactly 1 cycle):
  - cmd_ready = 0; uart_control[3:2] = 00. This guarantees the idle cycle the UART needs to detect the next edge.
  - uart_tx_data still held, because the UART writes its tx FIFO during this cycle.
  - READ: rsp_data <= uart_rx_data at the end of GAP; rsp_valid <= 1; next state RESP.
  - WRITE / CLEAR: next state IDLE.
- RESP:
  - cmd_ready = 0; uart_control[3:2] = 00.
  - rsp_valid and rsp_data are held stable until rsp_ready is sampled high. Then rsp_valid <= 0 and next state IDLE.
- After GAP or RESP, uart_tx_data returns to 0 in IDLE.
- Throughput: WRITE/CLEAR is one command per 3 cycles. READ is 3 cycles plus the response wait.
- Reading while the UART rx FIFO is empty is not blocked. rsp_data then carries whatever the UART returns (0x00 on underrun).
- No tx-FIFO occupancy is tracked. The host is responsible for pacing writes.
- rx_full and err are 1-cycle registered copies of uart_rts and uart_err.
- Reset mid-operation (PULSE, GAP or RESP): on the next cycle all outputs take their reset values, including the rate select.
  - The pending command is dropped and the pending response is lost.
  - If reset lands in PULSE, the UART sees at most that one non-zero pulse cycle.
- cmd_op/cmd_data changes while cmd_ready = 0 are ignored. Only values at the handshake edge are used.
- The uart_control[3:2] non-zero level never lasts more than 1 cycle and is never issued on two consecutive cycles.

Test Plan:
- Reset: assert syncReset for 2 cycles with DEFAULT_RATE_SEL = 2'b00. Required: uart_control = 4'b0000, cmd_ready = 1, rsp_valid = 0, uart_tx_data = 0x00.
- WRITE 0xA5 accepted at cycle T. Required:
  - cycle T+1: uart_control[3:2] = 01, uart_tx_data = 0xA5.
  - cycle T+2: uart_control[3:2] = 00, uart_tx_data = 0xA5.
  - cycle T+3: cmd_ready = 1, uart_tx_data = 0x00.
- READ accepted at T; model drives uart_rx_data = 0x3C only in cycle T+2. Required: uart_control[3:2] = 10 at T+1; rsp_valid = 1 with rsp_data = 0x3C from T+3.
- READ response backpressure: hold rsp_ready = 0 for 5 cycles. Required: rsp_data stays 0x3C and cmd_ready stays 0. Raise rsp_ready for one cycle. Required: rsp_valid = 0 and cmd_ready = 1 the next cycle.
- SET_RATE cmd_data = 0x03, then WRITE 0x11, then CLEAR, back-to-back with cmd_valid held high. Required:
  - uart_control[1:0] = 11 from the cycle after SET_RATE and on every later cycle.
  - Control[3:2] sequence is 01, 00, 00(IDLE), 11, 00. No two non-zero cycles are adjacent.
- Reset during GAP of a READ. Required: rsp_valid never asserts; uart_control = {2'b00, DEFAULT_RATE_SEL} the next cycle. Also drive uart_err = 1. Required: err = 1 one cycle later.
